term_event_fifo: RTL and testbench
==================================

Name: term_event_fifo

Overview:
- Downstream consumer of the 10-output `term1` combinational logic block; sits directly after it in the benchmark harness.
- Samples the 10-bit result vector when qualified by `in_valid`.
- On each change from the previously sampled value, logs an event {new vector, change mask, timestamp} into a small FIFO.
- Events drain through a valid/ready port; FIFO overflow is flagged stickily.

Parameters:
- WIDTH, 10, width of the sampled result vector (`term1` output count)
- DEPTH, 8, FIFO entries; power of two, >= 2
- TS_W, 16, timestamp counter width

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  `in_vec` is a qualified sample this cycle
- in_vec  input  WIDTH  result vector from upstream logic
- out_valid  output  1  head event available
- out_ready  input  1  consumer accepts head event this cycle
- out_vec  output  WIDTH  head event: sampled vector
- out_chg  output  WIDTH  head event: bitwise XOR with previous sample
- out_ts  output  TS_W  head event: timestamp of the sample
- count  output  $clog2(DEPTH)+1  entries held
- overflow  output  1  sticky: an event was dropped
- clr_ovf  input  1  clear overflow

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high (`rst`); all state is in the `clk` domain.
- Reset values:
  - `out_valid`=0, `count`=0, `overflow`=0.
  - Timestamp counter=0, baseline register=0.
  - FIFO read/write pointers=0.
  - State=INIT.
- State machine, two states:
  - INIT: waits for the first `in_valid`. That sample is stored as the baseline; no event is produced; state goes to TRACK.
  - TRACK: on `in_valid` with `in_vec` != baseline, an event is generated and the baseline takes `in_vec`. On `in_valid` with an equal vector, nothing happens.
  - No other transitions; only `rst` returns the block to INIT.
- Event contents:
  - `vec` = `in_vec`.
  - `chg` = `in_vec` ^ baseline. Never zero.
  - `ts` = counter value in the sample cycle.
- Timestamp counter:
  - Increments every cycle after reset.
  - Wraps modulo 2^TS_W with no flag.
- Latency: a sample in cycle N appears at the FIFO head (`out_valid`=1 when the FIFO was empty) in cycle N+1. There is no bypass.
- Handshake:
  - A pop occurs when `out_valid` && `out_ready`.
  - `out_vec`, `out_chg`, `out_ts` stay stable while `out_valid`=1 and no pop occurs.
  - When `out_valid`=0 the head outputs are don't-care.
- Full:
  - A push while full with no simultaneous pop is dropped and sets `overflow`.
  - The baseline is still updated, so later change masks are relative to the true last value.
- Full with simultaneous push and pop: both are accepted and `count` is unchanged.
- Empty with `out_ready`=1: no pop occurs and `count` stays 0.
- Push and pop in the same cycle at any occupancy: `count` is unchanged.
- Pointers:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - Full/empty is derived from `count`.
- `overflow`: `clr_ovf` clears it. If a drop occurs in the same cycle as `clr_ovf`, set wins.
- `rst` mid-operation: the FIFO contents are discarded and the block behaves as after power-up. The next `in_valid` sample is the new baseline.

Decomposition:
- Shared package holds:
  - Default constants TERM_W=10, EVT_DEPTH=8, EVT_TS_W=16.
  - The packed event typedef {vec, chg, ts} with its width function.
- One sub-module: `term_sync_fifo`, a generic synchronous FIFO.
  - Parameterised on data width and DEPTH.
  - Ports: push/pop/full/empty/count.
  - Has no overflow logic.
- `term_event_fifo` keeps the INIT/TRACK state, the baseline, the timestamp counter and the overflow flag.

Test Plan:
- Reset, then `in_valid`=1 with `in_vec`=0x2A5 in cycle 3 (ts=3) -> no event, `count`=0. Then 0x2A4 in cycle 5 -> cycle 6: `out_valid`=1, `out_vec`=0x2A4, `out_chg`=0x001, `out_ts`=5.
- Repeat an identical vector for 20 cycles with `in_valid`=1 -> `count` stays 0 and `out_valid` stays 0.
- `out_ready`=0; present 9 distinct changing vectors (DEPTH=8) -> `count`=8 and `overflow`=1. The head holds the first event. The 9th event is absent. A 10th vector's `out_chg` is computed against the 9th vector.
- FIFO full with `out_ready`=1 and a change in the same cycle -> pop and push both occur, `count` stays 8, and the popped order is FIFO.
- `overflow`=1, then `clr_ovf`=1 in the same cycle as a new drop -> `overflow` remains 1. Next cycle, `clr_ovf`=1 with no drop -> `overflow`=0.
- `rst` asserted for 1 cycle while `count`=5 -> `count`=0, `out_valid`=0, ts restarts at 0. The next sample after `rst` is a baseline only and produces no event.

Source files
------------

// File: rtl/term_event_fifo_pkg.sv
// Shared constants, state encoding and event payload for the term1 change-event logger.
package term_event_fifo_pkg;

    localparam int unsigned TERM_W    = 10;
    localparam int unsigned EVT_DEPTH = 8;
    localparam int unsigned EVT_TS_W  = 16;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } trk_state_t;

    typedef struct packed {
        logic [TERM_W-1:0]   vec;
        logic [TERM_W-1:0]   chg;
        logic [EVT_TS_W-1:0] ts;
    } term_evt_t;

    function automatic int unsigned evt_w(input int unsigned w, input int unsigned ts_w);
        return 2 * w + ts_w;
    endfunction

endpackage

// File: rtl/term_sync_fifo.sv
// Generic single-clock FIFO; push while full is accepted only alongside a pop.
module term_sync_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            din,
    input  logic                     pop,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/term_event_fifo.sv
// Logs changes of the sampled term1 result vector as {vec, chg, ts} events into a FIFO.
module term_event_fifo
    import term_event_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = TERM_W,
    parameter int unsigned DEPTH = EVT_DEPTH,
    parameter int unsigned TS_W  = EVT_TS_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_vec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_vec,
    output logic [WIDTH-1:0]       out_chg,
    output logic [TS_W-1:0]        out_ts,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   clr_ovf
);

    localparam int unsigned EW = evt_w(WIDTH, TS_W);

    trk_state_t       state_q;
    trk_state_t       state_d;
    logic [WIDTH-1:0] base_q;
    logic [TS_W-1:0]  ts_q;
    logic [WIDTH-1:0] chg_c;
    logic             evt_push_c;
    logic             base_ld_c;
    logic             drop_c;
    logic             pop_c;
    logic             full;
    logic             empty;
    logic [EW-1:0]    wr_data;
    logic [EW-1:0]    rd_data;

    assign chg_c     = in_vec ^ base_q;
    assign wr_data   = {in_vec, chg_c, ts_q};
    assign out_valid = !empty;
    assign pop_c     = out_valid && out_ready;
    assign drop_c    = evt_push_c && full && !pop_c;

    assign out_vec = rd_data[EW-1 -: WIDTH];
    assign out_chg = rd_data[TS_W +: WIDTH];
    assign out_ts  = rd_data[TS_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // First qualified sample only seeds the baseline; later ones log on change.
    always_comb begin
        state_d    = state_q;
        evt_push_c = 1'b0;
        base_ld_c  = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (in_valid) begin
                    base_ld_c = 1'b1;
                    state_d   = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (in_valid && (in_vec != base_q)) begin
                    evt_push_c = 1'b1;
                    base_ld_c  = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Baseline follows every change, even a dropped one, so masks stay truthful.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q   <= '0;
            ts_q     <= '0;
            overflow <= 1'b0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (base_ld_c) begin
                base_q <= in_vec;
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    term_sync_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (evt_push_c),
        .din   (wr_data),
        .pop   (pop_c),
        .dout  (rd_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_term_event_fifo.sv
// Scoreboard bench for term_event_fifo: reference model pushes expected events, monitor pops on handshake.
module tb_term_event_fifo;
    import term_event_fifo_pkg::*;

    localparam int unsigned W  = TERM_W;
    localparam int unsigned D  = EVT_DEPTH;
    localparam int unsigned TW = EVT_TS_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_vec;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_vec;
    logic [W-1:0]  out_chg;
    logic [TW-1:0] out_ts;
    logic [3:0]    count;
    logic          overflow;
    logic          clr_ovf;

    int total = 0;
    int bad   = 0;

    term_evt_t     exp_q[$];
    bit            have_base;
    logic [W-1:0]  base_m;
    int unsigned   ts_m;
    bit            ovf_m;

    term_event_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_chg   (out_chg),
        .out_ts    (out_ts),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: change log of qualified samples with a bounded queue.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            have_base = 1'b0;
            base_m    = '0;
            ts_m      = 0;
            ovf_m     = 1'b0;
        end else begin
            bit dropped;
            dropped = 1'b0;
            if (in_valid) begin
                if (!have_base) begin
                    have_base = 1'b1;
                    base_m    = in_vec;
                end else if (in_vec != base_m) begin
                    term_evt_t e;
                    e.vec = in_vec;
                    e.chg = in_vec ^ base_m;
                    e.ts  = TW'(ts_m);
                    if (exp_q.size() < D) exp_q.push_back(e);
                    else dropped = 1'b1;
                    base_m = in_vec;
                end
            end
            if (dropped) ovf_m = 1'b1;
            else if (clr_ovf) ovf_m = 1'b0;
            ts_m = (ts_m + 1) % (1 << TW);
        end
    end

    // Monitor: compares outputs away from the edge and retires expected events on handshake.
    always @(negedge clk) begin
        check("count", 32'(count), 32'(exp_q.size()));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("overflow", 32'(overflow), 32'(ovf_m));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("head_unexpected", 32'(out_valid), 32'(0));
            end else begin
                check("out_vec", 32'(out_vec), 32'(exp_q[0].vec));
                check("out_chg", 32'(out_chg), 32'(exp_q[0].chg));
                check("out_ts", 32'(out_ts), 32'(exp_q[0].ts));
                if (out_ready && !rst) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] vec, input logic rdy, input logic clr);
        in_valid  = v;
        in_vec    = vec;
        out_ready = rdy;
        clr_ovf   = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] pool [4];
        rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("rst_count", 32'(count), 32'(0));
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));

        // Baseline in cycle 3, first change in cycle 5.
        drive(0, '0, 0, 0); drive(0, '0, 0, 0); drive(0, '0, 0, 0);
        drive(1, 10'h2A5, 0, 0);
        check("baseline_no_evt", 32'(count), 32'(0));
        drive(0, '0, 0, 0);
        drive(1, 10'h2A4, 0, 0);
        check("first_valid", 32'(out_valid), 32'(1));
        check("first_vec", 32'(out_vec), 32'h2A4);
        check("first_chg", 32'(out_chg), 32'h001);
        check("first_ts", 32'(out_ts), 32'd5);
        drive(0, '0, 1, 0);

        // Repeated identical vector produces nothing.
        for (int i = 0; i < 20; i++) drive(1, 10'h2A4, 1, 0);
        check("repeat_count", 32'(count), 32'(0));
        check("repeat_valid", 32'(out_valid), 32'(0));

        // Nine changes with a stalled consumer: eighth fills, ninth drops.
        for (int i = 1; i <= 9; i++) drive(1, W'(10'h100 + i), 0, 0);
        check("full_count", 32'(count), 32'(8));
        check("full_ovf", 32'(overflow), 32'(1));
        check("full_head", 32'(out_vec), 32'h101);

        // Full with simultaneous pop and push; mask is against the dropped ninth value.
        drive(1, 10'h3FF, 1, 0);
        check("pp_count", 32'(count), 32'(8));
        check("pp_head", 32'(out_vec), 32'h102);

        // Clear colliding with a new drop loses; clear alone wins.
        drive(1, 10'h000, 0, 1);
        check("ovf_set_wins", 32'(overflow), 32'(1));
        drive(0, '0, 0, 1);
        check("ovf_cleared", 32'(overflow), 32'(0));

        // Drain to five entries, then reset mid-flight.
        for (int i = 0; i < 3; i++) drive(0, '0, 1, 0);
        check("pre_rst_count", 32'(count), 32'(5));
        rst = 1'b1;
        drive(0, '0, 0, 0);
        rst = 1'b0;
        check("mid_rst_count", 32'(count), 32'(0));
        check("mid_rst_valid", 32'(out_valid), 32'(0));
        drive(1, 10'h055, 0, 0);
        check("post_rst_baseline", 32'(count), 32'(0));
        drive(1, 10'h056, 0, 0);
        check("post_rst_ts", 32'(out_ts), 32'd1);
        check("post_rst_chg", 32'(out_chg), 32'h003);

        // Randomized traffic over a small value pool to mix repeats and changes.
        pool[0] = 10'h000; pool[1] = 10'h3FF; pool[2] = 10'h155; pool[3] = W'($urandom);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            drive(1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)],
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
            if ((i % 200) == 0) pool[3] = W'($urandom);
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) drive(0, '0, 1, 0);
        @(negedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
